alu_ctrl_pipe: RTL

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

---
 rtl/alu_ctrl_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder with a valid/ready output stage; RV32M ops take a fixed
// multi-cycle issue slot through a small IDLE/MD_BUSY controller.
module alu_ctrl_pipe #(
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter int unsigned OP_WIDTH    = 7,
  parameter int unsigned F3_WIDTH    = 3,
  parameter int unsigned F7_WIDTH    = 7,
  parameter int unsigned CTRL_WIDTH  = 4,
  parameter int unsigned M_EXT       = 1,
  parameter int unsigned MD_LATENCY  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [F3_WIDTH-1:0]    funct3,
  input  logic [F7_WIDTH-1:0]    funct7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  alu_ctrl,
  output logic                   md_op,
  output logic                   illegal,
  output logic                   md_busy
);

  localparam int unsigned CNT_W = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 2);

  localparam logic [3:0] C_ADD   = 4'd0;
  localparam logic [3:0] C_SUB   = 4'd1;
  localparam logic [3:0] C_SLL   = 4'd2;
  localparam logic [3:0] C_SLT   = 4'd3;
  localparam logic [3:0] C_SLTU  = 4'd4;
  localparam logic [3:0] C_XOR   = 4'd5;
  localparam logic [3:0] C_SRL   = 4'd6;
  localparam logic [3:0] C_SRA   = 4'd7;
  localparam logic [3:0] C_OR    = 4'd8;
  localparam logic [3:0] C_AND   = 4'd9;
  localparam logic [3:0] C_PASSB = 4'd10;

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic                 md_op_q, md_op_d;
  logic                 illegal_q, illegal_d;

  logic [3:0] dec_ctrl;
  logic       dec_md;
  logic       dec_ill;
  logic       accept;
  logic       unused_op;

  logic [2:0] f3;
  logic       is_m;
  logic       f7_zero;
  logic       f7_alt;

  assign f3        = funct3[2:0];
  assign is_m      = op[5] && (funct7 == F7_WIDTH'(7'b0000001));
  assign f7_zero   = (funct7 == '0);
  assign f7_alt    = (funct7 == F7_WIDTH'(7'b0100000));
  assign unused_op = ^op;

  // Instruction-class decode; funct7 only matters for the R/I ALU class.
  always_comb begin
    dec_ctrl = C_ADD;
    dec_md   = 1'b0;
    dec_ill  = 1'b0;
    case (alu_op)
      ALUOP_WIDTH'(0): begin
        if (is_m) begin
          if (M_EXT != 0) begin
            dec_md   = 1'b1;
            dec_ctrl = {1'b0, f3};
          end else begin
            dec_ill  = 1'b1;
          end
        end else if (f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101))) begin
          case (f3)
            3'b000:  dec_ctrl = (op[5] && funct7[5]) ? C_SUB : C_ADD;
            3'b001:  dec_ctrl = C_SLL;
            3'b010:  dec_ctrl = C_SLT;
            3'b011:  dec_ctrl = C_SLTU;
            3'b100:  dec_ctrl = C_XOR;
            3'b101:  dec_ctrl = funct7[5] ? C_SRA : C_SRL;
            3'b110:  dec_ctrl = C_OR;
            default: dec_ctrl = C_AND;
          endcase
        end else begin
          dec_ill = 1'b1;
        end
      end
      ALUOP_WIDTH'(3): begin
        case (f3[2:1])
          2'b00:   dec_ctrl = C_SUB;
          2'b10:   dec_ctrl = C_SLT;
          2'b11:   dec_ctrl = C_SLTU;
          default: dec_ctrl = C_ADD;
        endcase
      end
      ALUOP_WIDTH'(5): dec_ctrl = C_PASSB;
      default:         dec_ctrl = C_ADD;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && dec_md) state_d = MD_BUSY;
      MD_BUSY: if (cnt_q == '0)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result fields load on accept; M ops hold out_valid low until the countdown ends.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    md_op_d     = md_op_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_ctrl_d  = CTRL_WIDTH'(dec_ctrl);
          md_op_d     = dec_md;
          illegal_d   = dec_ill;
          out_valid_d = !dec_md;
          cnt_d       = dec_md ? CNT_LOAD : '0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) out_valid_d = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      md_op_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      md_op_q     <= md_op_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign md_op     = md_op_q;
  assign illegal   = illegal_q;
  assign md_busy   = (state_q == MD_BUSY);

endmodule
